// File: rtl/fp_seq.sv
// FPU phase sequencer: drives the F-PM phase lines and strobes, steps through
// the F2..F13 phases from F-PM decode/status, and reports busy/done/fault.
module fp_seq #(
  parameter int unsigned PHASE_TICKS = 8,
  parameter int unsigned STROB1_AT   = 2,
  parameter int unsigned STROB2_AT   = 5,
  parameter int unsigned LOOP_MAX    = 63
) (
  input  logic __clk,
  input  logic _0_f_,
  input  logic fstart,
  input  logic fabort,
  input  logic nrf,
  input  logic af_sf,
  input  logic mw_mf,
  input  logic dw_df,
  input  logic df,
  input  logic ff,
  input  logic fic,
  input  logic _end,
  output logic f2_,
  output logic f4_,
  output logic f5_,
  output logic f6_,
  output logic f7_,
  output logic f8_,
  output logic f10_,
  output logic f9,
  output logic f13,
  output logic strob_fp_,
  output logic strob2_fp,
  output logic fbusy,
  output logic fdone,
  output logic ffault
);

  localparam int unsigned TW = (PHASE_TICKS > 1) ? $clog2(PHASE_TICKS) : 1;
  localparam int unsigned LW = (LOOP_MAX > 0) ? $clog2(LOOP_MAX + 1) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(PHASE_TICKS - 1);
  localparam logic [TW-1:0] TICK_S1   = TW'(STROB1_AT);
  localparam logic [TW-1:0] TICK_S2   = TW'(STROB2_AT);
  localparam logic [LW-1:0] LOOP_LIM  = LW'(LOOP_MAX);

  typedef enum logic [3:0] {
    S_IDLE, S_F2, S_F4, S_F5, S_F6, S_F7, S_F8, S_F9, S_F10, S_F13
  } state_t;

  state_t        state, nxt_state;
  logic [TW-1:0] tick, nxt_tick;
  logic [LW-1:0] loop, nxt_loop;
  logic          set_fault, set_done;
  logic          mul_div;
  logic          loop_full;

  assign mul_div   = mw_mf | dw_df;
  assign loop_full = (loop == LOOP_LIM);

  always_comb begin
    nxt_state = state;
    nxt_tick  = tick;
    nxt_loop  = loop;
    set_fault = 1'b0;
    set_done  = 1'b0;
    if (state == S_IDLE) begin
      nxt_tick = '0;
      if (fstart) begin
        nxt_state = S_F2;
        nxt_loop  = '0;
      end
    end else if (fabort) begin
      nxt_state = S_IDLE;
      nxt_tick  = '0;
      set_fault = 1'b1;
    end else if (tick != TICK_LAST) begin
      nxt_tick = tick + 1'b1;
    end else begin
      nxt_tick = '0;
      case (state)
        S_F2: begin
          nxt_loop = '0;
          if (nrf)          nxt_state = S_F6;
          else if (af_sf)   nxt_state = S_F5;
          else if (mul_div) nxt_state = S_F4;
          else begin
            nxt_state = S_IDLE;
            set_fault = 1'b1;
          end
        end
        S_F5: begin
          nxt_loop  = '0;
          nxt_state = fic ? S_F8 : S_F4;
        end
        // Re-entering a looping phase counts one iteration; a further pass
        // once the count has reached LOOP_MAX aborts the sequence as a fault.
        S_F8: begin
          if (!fic) begin
            nxt_state = S_F4;
            nxt_loop  = '0;
          end else if (loop_full) begin
            nxt_state = S_IDLE;
            set_fault = 1'b1;
          end else begin
            nxt_loop = loop + 1'b1;
          end
        end
        S_F4: begin
          if (mul_div && fic) begin
            if (loop_full) begin
              nxt_state = S_IDLE;
              set_fault = 1'b1;
            end else begin
              nxt_loop = loop + 1'b1;
            end
          end else begin
            nxt_loop  = '0;
            nxt_state = (mul_div && df) ? S_F9 : S_F6;
          end
        end
        S_F9: begin
          nxt_state = S_F6;
          nxt_loop  = '0;
        end
        S_F6: nxt_state = S_F7;
        S_F7: begin
          if (_end) begin
            nxt_state = S_F10;
          end else if (loop_full) begin
            nxt_state = S_IDLE;
            set_fault = 1'b1;
          end else begin
            nxt_state = S_F6;
            nxt_loop  = loop + 1'b1;
          end
        end
        S_F10: begin
          if (ff) begin
            nxt_state = S_F13;
          end else begin
            nxt_state = S_IDLE;
            set_done  = 1'b1;
          end
        end
        S_F13: begin
          nxt_state = S_IDLE;
          set_done  = 1'b1;
        end
        default: nxt_state = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state/tick so they line up with the
  // registered state rather than lagging it by a clock.
  always_ff @(posedge __clk or negedge _0_f_) begin
    if (!_0_f_) begin
      state     <= S_IDLE;
      tick      <= '0;
      loop      <= '0;
      f2_       <= 1'b1;
      f4_       <= 1'b1;
      f5_       <= 1'b1;
      f6_       <= 1'b1;
      f7_       <= 1'b1;
      f8_       <= 1'b1;
      f10_      <= 1'b1;
      f9        <= 1'b0;
      f13       <= 1'b0;
      strob_fp_ <= 1'b1;
      strob2_fp <= 1'b0;
      fbusy     <= 1'b0;
      fdone     <= 1'b0;
      ffault    <= 1'b0;
    end else begin
      state     <= nxt_state;
      tick      <= nxt_tick;
      loop      <= nxt_loop;
      f2_       <= (nxt_state != S_F2);
      f4_       <= (nxt_state != S_F4);
      f5_       <= (nxt_state != S_F5);
      f6_       <= (nxt_state != S_F6);
      f7_       <= (nxt_state != S_F7);
      f8_       <= (nxt_state != S_F8);
      f10_      <= (nxt_state != S_F10);
      f9        <= (nxt_state == S_F9);
      f13       <= (nxt_state == S_F13);
      strob_fp_ <= !((nxt_state != S_IDLE) && (nxt_tick == TICK_S1));
      strob2_fp <= (nxt_state != S_IDLE) && (nxt_tick == TICK_S2);
      fbusy     <= (nxt_state != S_IDLE);
      fdone     <= set_done;
      if (state == S_IDLE && fstart) ffault <= 1'b0;
      else if (set_fault)            ffault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fp_seq.sv
// Bench for fp_seq: phase-level reference model driving per-clock expected
// waveforms, a directed case table, random cases and reset/abort sequences.
module tb_fp_seq;

  localparam int PHASE_TICKS = 8;
  localparam int STROB1_AT   = 2;
  localparam int STROB2_AT   = 5;
  localparam int LOOP_MAX    = 63;
  localparam int MAXPH       = 300;

  logic clk = 1'b0;
  logic rst_n;
  logic fstart, fabort, nrf, af_sf, mw_mf, dw_df, df, ff, fic, end_in;
  logic f2_, f4_, f5_, f6_, f7_, f8_, f10_, f9, f13;
  logic strob_fp_, strob2_fp, fbusy, fdone, ffault;

  int n_vec = 0;
  int n_err = 0;

  fp_seq #(
    .PHASE_TICKS(PHASE_TICKS),
    .STROB1_AT  (STROB1_AT),
    .STROB2_AT  (STROB2_AT),
    .LOOP_MAX   (LOOP_MAX)
  ) dut (
    .__clk    (clk),
    ._0_f_    (rst_n),
    .fstart   (fstart),
    .fabort   (fabort),
    .nrf      (nrf),
    .af_sf    (af_sf),
    .mw_mf    (mw_mf),
    .dw_df    (dw_df),
    .df       (df),
    .ff       (ff),
    .fic      (fic),
    ._end     (end_in),
    .f2_      (f2_),
    .f4_      (f4_),
    .f5_      (f5_),
    .f6_      (f6_),
    .f7_      (f7_),
    .f8_      (f8_),
    .f10_     (f10_),
    .f9       (f9),
    .f13      (f13),
    .strob_fp_(strob_fp_),
    .strob2_fp(strob2_fp),
    .fbusy    (fbusy),
    .fdone    (fdone),
    .ffault   (ffault)
  );

  always #5 clk = ~clk;

  // cls bits: [5]nrf [4]af_sf [3]mw_mf [2]dw_df [1]df [0]ff
  typedef struct {
    logic [5:0]   cls;
    logic [127:0] fic_m;
    logic [127:0] end_m;
    int           abort_ph, abort_tk;
    int           start_ph, start_tk;
    bit           start_abort;
    int           exp_busy;
    bit           exp_done, exp_fault;
  } case_t;

  function automatic case_t mk(input logic [5:0] cls, input logic [127:0] fm,
                               input logic [127:0] em, input int aph, input int atk,
                               input int sph, input int stk, input bit sa,
                               input int eb, input bit ed, input bit ef);
    case_t c;
    c.cls = cls; c.fic_m = fm; c.end_m = em;
    c.abort_ph = aph; c.abort_tk = atk; c.start_ph = sph; c.start_tk = stk;
    c.start_abort = sa; c.exp_busy = eb; c.exp_done = ed; c.exp_fault = ef;
    return c;
  endfunction

  // Expected output bundle for phase number ph (0 = idle) at tick t.
  function automatic logic [13:0] exp_out(input int ph, input int t, input bit dn, input bit flt);
    bit act;
    act = (ph != 0);
    return {ph != 2, ph != 4, ph != 5, ph != 6, ph != 7, ph != 8, ph != 10,
            ph == 9, ph == 13, !(act && t == STROB1_AT), act && t == STROB2_AT,
            act, dn, flt};
  endfunction

  // Phase-level rules: next phase from the current one; loop counts how many
  // times a looping phase (F8, F4, or the F6/F7 pair) has been repeated.
  function automatic void model_step(input int ph, input logic [5:0] cls, input bit fic_b,
                                     input bit end_b, inout int loop, output int nph,
                                     output bit flt, output bit dn);
    bit md;
    bit rep;
    md = cls[3] | cls[2];
    flt = 0; dn = 0; nph = 0;
    case (ph)
      2:  nph = cls[5] ? 6 : cls[4] ? 5 : md ? 4 : 0;
      5:  nph = fic_b ? 8 : 4;
      8:  nph = fic_b ? 8 : 4;
      4:  nph = (md && fic_b) ? 4 : (md && cls[1]) ? 9 : 6;
      9:  nph = 6;
      6:  nph = 7;
      7:  nph = end_b ? 10 : 6;
      10: nph = cls[0] ? 13 : 0;
      default: nph = 0;
    endcase
    if (ph == 2 && nph == 0) flt = 1;
    if ((ph == 10 || ph == 13) && nph == 0) dn = 1;
    rep = (ph == nph) || (ph == 7 && nph == 6);
    if (rep) begin
      if (loop == LOOP_MAX) begin flt = 1; nph = 0; end
      else loop++;
    end else if (!(ph == 6 && nph == 7)) begin
      loop = 0;
    end
  endfunction

  task automatic check(input string name, input logic [13:0] exp);
    logic [13:0] act;
    act = {f2_, f4_, f5_, f6_, f7_, f8_, f10_, f9, f13, strob_fp_, strob2_fp, fbusy, fdone, ffault};
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic run_case(input int id, input case_t c);
    int ph, p, loop, nph, busy;
    bit flt, dn, aborted, mflt, mdn, fic_b, end_b, obs_done, obs_fault;
    {nrf, af_sf, mw_mf, dw_df, df, ff} = c.cls;
    fic = 0; end_in = 0;
    fstart = 1; fabort = c.start_abort;
    @(posedge clk); #1;
    fstart = 0; fabort = 0;
    ph = 2; p = 0; loop = 0; busy = 0; flt = 0; dn = 0; aborted = 0;
    while (ph != 0 && p < MAXPH) begin
      fic_b = (p < 128) ? c.fic_m[p[6:0]] : 1'b0;
      end_b = (p < 128) ? c.end_m[p[6:0]] : 1'b0;
      fic = fic_b; end_in = end_b;
      for (int t = 0; t < PHASE_TICKS && !aborted; t++) begin
        check($sformatf("c%0d p%0d F%0d t%0d", id, p, ph, t), exp_out(ph, t, 0, 0));
        if (fbusy) busy++;
        if (p == c.start_ph && t == c.start_tk) fstart = 1;
        if (p == c.abort_ph && t == c.abort_tk) fabort = 1;
        @(posedge clk); #1;
        fstart = 0;
        if (fabort) begin fabort = 0; aborted = 1; end
      end
      if (aborted) begin
        ph = 0; flt = 1; dn = 0;
      end else begin
        model_step(ph, c.cls, fic_b, end_b, loop, nph, mflt, mdn);
        ph = nph; flt = mflt; dn = mdn;
      end
      p++;
    end
    if (ph != 0) begin
      n_vec++; n_err++;
      $display("FAIL c%0d bound: still sequencing after %0d phases, required idle", id, p);
    end
    check($sformatf("c%0d end", id), exp_out(0, 0, dn, flt));
    obs_done = fdone; obs_fault = ffault;
    @(posedge clk); #1;
    check($sformatf("c%0d idle", id), exp_out(0, 0, 0, flt));
    if (c.exp_busy >= 0) begin
      n_vec++;
      if (busy != c.exp_busy || obs_done != c.exp_done || obs_fault != c.exp_fault) begin
        n_err++;
        $display("FAIL c%0d summary: busy=%0d done=%0b fault=%0b required busy=%0d done=%0b fault=%0b",
                 id, busy, obs_done, obs_fault, c.exp_busy, c.exp_done, c.exp_fault);
      end
    end
  endtask

  case_t tbl[11];

  initial begin
    case_t rc;
    rst_n = 0; fstart = 0; fabort = 0;
    {nrf, af_sf, mw_mf, dw_df, df, ff, fic, end_in} = '0;

    tbl[0]  = mk(6'b010001, 128'h1E, 128'h100, -1, 0, -1, 0, 0, 88, 1, 0);   // add float, F8x4, F13
    tbl[1]  = mk(6'b000110, 128'h6, 128'h40, -1, 0, -1, 0, 0, 64, 1, 0);     // divide float, F4x3, F9
    tbl[2]  = mk(6'b100000, '0, '0, -1, 0, -1, 0, 0, 1032, 0, 1);            // nrf, F6/F7 limit
    tbl[3]  = mk(6'b000000, '0, '0, -1, 0, -1, 0, 0, 8, 0, 1);               // no class -> fault
    tbl[4]  = mk(6'b001000, 128'h2, 128'h10, -1, 0, -1, 0, 0, 48, 1, 0);     // multiply word
    tbl[5]  = mk(6'b001000, 128'h2, 128'h10, 1, 1, -1, 0, 0, 10, 0, 1);      // abort before F4 strobe
    tbl[6]  = mk(6'b010001, 128'h1E, 128'h100, -1, 0, 7, 3, 0, 88, 1, 0);    // fstart in F6 ignored
    tbl[7]  = mk(6'b000110, 128'h6, 128'h40, 6, 7, -1, 0, 0, 56, 0, 1);      // abort on branch tick
    tbl[8]  = mk(6'b010000, '1, '0, -1, 0, -1, 0, 0, 528, 0, 1);             // F8 limit
    tbl[9]  = mk(6'b010000, {63'b0, {65{1'b1}}}, 128'(1) << 68, -1, 0, -1, 0, 0, 560, 1, 0); // F8 exit at limit
    tbl[10] = mk(6'b001000, 128'h2, 128'h10, -1, 0, -1, 0, 1, 48, 1, 0);     // fstart+fabort in idle

    repeat (2) @(posedge clk);
    #1 check("reset", exp_out(0, 0, 0, 0));
    #2 rst_n = 1;

    // Reset asserted mid-F8 (tick 3) clears outputs immediately.
    af_sf = 1; fic = 1;
    @(posedge clk); #1 fstart = 1;
    @(posedge clk); #1 fstart = 0;
    repeat (19) @(posedge clk);
    #1 check("pre-reset F8 t3", exp_out(8, 3, 0, 0));
    #2 rst_n = 0;
    #1 check("async reset", exp_out(0, 0, 0, 0));
    @(posedge clk); #2 rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 check($sformatf("post-reset idle %0d", i), exp_out(0, 0, 0, 0));
    end
    af_sf = 0; fic = 0;

    // fabort in idle has no effect.
    fabort = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 check($sformatf("idle abort %0d", i), exp_out(0, 0, 0, 0));
    end
    fabort = 0;

    for (int i = 0; i < 11; i++) run_case(i, tbl[i]);

    for (int r = 0; r < 20; r++) begin
      rc.cls = 6'($urandom_range(0, 63));
      rc.fic_m = {$urandom, $urandom, $urandom, $urandom};
      rc.end_m = {$urandom, $urandom, $urandom, $urandom} & {$urandom, $urandom, $urandom, $urandom};
      rc.abort_ph = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1;
      rc.abort_tk = int'($urandom_range(0, PHASE_TICKS - 1));
      rc.start_ph = int'($urandom_range(0, 10));
      rc.start_tk = int'($urandom_range(0, PHASE_TICKS - 1));
      rc.start_abort = 1'($urandom_range(0, 1));
      rc.exp_busy = -1; rc.exp_done = 0; rc.exp_fault = 0;
      run_case(100 + r, rc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
